// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_pkg
// Description : Shared LEGv8 encode/decode definitions: operation selector,
//               opcode fields, fixed sub-fields and immediate range limits.
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

  localparam int c_op_w   = 4;
  localparam int c_reg_w  = 5;
  localparam int c_imm_w  = 26;
  localparam int c_word_w = 32;

  // Operation selector presented on the loader's op input
  typedef enum logic [c_op_w-1:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_SUBS = 4'd2,
    OP_B    = 4'd3,
    OP_CBZ  = 4'd4,
    OP_BLT  = 4'd5,
    OP_LDUR = 4'd6,
    OP_STUR = 4'd7,
    OP_LSL  = 4'd8,
    OP_LSR  = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  // 11-bit R-type / D-type opcodes
  localparam logic [10:0] c_opc_adds = 11'b10101011000;
  localparam logic [10:0] c_opc_subs = 11'b11101011000;
  localparam logic [10:0] c_opc_lsl  = 11'b11010011011;
  localparam logic [10:0] c_opc_lsr  = 11'b11010011010;
  localparam logic [10:0] c_opc_mul  = 11'b10011011000;
  localparam logic [10:0] c_opc_ldur = 11'b11111000010;
  localparam logic [10:0] c_opc_stur = 11'b11111000000;

  // Shorter opcodes for I-, B- and CB-type formats
  localparam logic [9:0]  c_opc_addi = 10'b1001000100;
  localparam logic [5:0]  c_opc_b    = 6'b000101;
  localparam logic [7:0]  c_opc_cbz  = 8'b10110100;
  localparam logic [7:0]  c_opc_blt  = 8'b01010100;

  // Fixed sub-fields
  localparam logic [4:0]  c_blt_cond  = 5'b01011;
  localparam logic [5:0]  c_mul_shamt = 6'b011111;

  // Legal immediate ranges (two's complement on the 26-bit imm input)
  localparam logic signed [c_imm_w-1:0] c_imm_zero  = 26'sd0;
  localparam logic signed [c_imm_w-1:0] c_addi_max  = 26'sd4095;
  localparam logic signed [c_imm_w-1:0] c_shift_max = 26'sd63;
  localparam logic signed [c_imm_w-1:0] c_ldst_min  = -26'sd256;
  localparam logic signed [c_imm_w-1:0] c_ldst_max  = 26'sd255;
  localparam logic signed [c_imm_w-1:0] c_br_min    = -26'sd262144;
  localparam logic signed [c_imm_w-1:0] c_br_max    = 26'sd262143;

  // True when v lies in the inclusive signed range [lo, hi]
  function automatic logic in_range(input logic signed [c_imm_w-1:0] v,
                                    input logic signed [c_imm_w-1:0] lo,
                                    input logic signed [c_imm_w-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_field_encoder.sv
`default_nettype none
// ============================================================================
// Module      : legv8_field_encoder
// Description : Combinational LEGv8 field packer. Builds the 32-bit machine
//               word for the selected operation and flags out-of-range
//               immediates or unknown operation selectors.
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_field_encoder
  import legv8_pkg::*;
(
  input  logic [c_op_w-1:0]   op,
  input  logic [c_reg_w-1:0]  rd,
  input  logic [c_reg_w-1:0]  rn,
  input  logic [c_reg_w-1:0]  rm,
  input  logic [c_imm_w-1:0]  imm,
  output logic [c_word_w-1:0] word,
  output logic                illegal
);

  op_t                        w_op;
  logic signed [c_imm_w-1:0]  w_simm;

  assign w_op   = op_t'(op);
  assign w_simm = $signed(imm);

  // Pack fields per instruction format and range-check the immediate
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (w_op)
      OP_ADDI: begin
        word    = {c_opc_addi, imm[11:0], rn, rd};
        illegal = !in_range(w_simm, c_imm_zero, c_addi_max);
      end
      OP_ADDS: word = {c_opc_adds, rm, 6'd0, rn, rd};
      OP_SUBS: word = {c_opc_subs, rm, 6'd0, rn, rd};
      OP_MUL:  word = {c_opc_mul, rm, c_mul_shamt, rn, rd};
      OP_LSL: begin
        word    = {c_opc_lsl, 5'd0, imm[5:0], rn, rd};
        illegal = !in_range(w_simm, c_imm_zero, c_shift_max);
      end
      OP_LSR: begin
        word    = {c_opc_lsr, 5'd0, imm[5:0], rn, rd};
        illegal = !in_range(w_simm, c_imm_zero, c_shift_max);
      end
      OP_LDUR: begin
        word    = {c_opc_ldur, imm[8:0], 2'b00, rn, rd};
        illegal = !in_range(w_simm, c_ldst_min, c_ldst_max);
      end
      OP_STUR: begin
        word    = {c_opc_stur, imm[8:0], 2'b00, rn, rd};
        illegal = !in_range(w_simm, c_ldst_min, c_ldst_max);
      end
      OP_B:    word = {c_opc_b, imm};
      OP_CBZ: begin
        word    = {c_opc_cbz, imm[18:0], rd};
        illegal = !in_range(w_simm, c_br_min, c_br_max);
      end
      OP_BLT: begin
        word    = {c_opc_blt, imm[18:0], c_blt_cond};
        illegal = !in_range(w_simm, c_br_min, c_br_max);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Session-based LEGv8 program loader. Accepts decoded field
//               bundles, encodes them and writes one word per cycle into
//               instruction memory starting at base_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
  import legv8_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [c_op_w-1:0]     op,
  input  logic [c_reg_w-1:0]    rd,
  input  logic [c_reg_w-1:0]    rn,
  input  logic [c_reg_w-1:0]    rm,
  input  logic [c_imm_w-1:0]    imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [c_word_w-1:0]   wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  full,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_last  = c_depth - (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [c_word_w-1:0]   r_wr_data;
  logic                  r_done;
  logic                  r_full;
  logic                  r_error;

  logic [c_word_w-1:0]   w_word;
  logic                  w_illegal;
  logic                  w_ready;
  logic                  w_hs;
  logic                  w_last;

  legv8_field_encoder u_enc (
    .op      (op),
    .rd      (rd),
    .rn      (rn),
    .rm      (rm),
    .imm     (imm),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // A pointer parked outside the memory (bad base_addr) never accepts a bundle
  assign w_ready = (r_state == S_RUN) && ({1'b0, r_ptr} < c_depth);
  assign w_hs    = in_valid & w_ready;
  assign w_last  = ({1'b0, r_ptr} == c_last);

  // Session FSM with write pointer, word count, write port and sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_RUN;
            r_ptr   <= base_addr;
            r_count <= '0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_hs && w_illegal) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else if (w_hs) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ptr;
            r_wr_data <= w_word;
            r_ptr     <= r_ptr + ADDR_WIDTH'(1);
            r_count   <= r_count + (ADDR_WIDTH+1)'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_full  <= 1'b1;
            end else if (finish) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (finish) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = w_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign count    = r_count;
  assign done     = r_done;
  assign full     = r_full;
  assign error    = r_error;

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Assembles LEGv8 instructions from decoded fields (opcode selector, registers, immediate) into 32-bit machine words and writes them sequentially into instruction memory. It is the encode side of the control decoder: every word it emits, once fetched, must decode to the same operation in the single-cycle CPU. It sits between the testbench or boot host and the instruction memory write port, and is used to load programs without external hex files.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width.
- `IMEM_DEPTH`, default 1024: number of words; the last valid address is IMEM_DEPTH-1.
- `clk`  in  1  : single clock; all state changes on its rising edge.
- `reset`  in  1  : synchronous, active-low reset.
- `start`  in  1  : one-cycle pulse; loads `base_addr`, clears `count`/`done`/`error`/`full`.
- `base_addr`  in  ADDR_WIDTH  : first word address written.
- `finish`  in  1  : ends the load session.
- `in_valid`  in  1  : field bundle valid.
- `in_ready`  out  1  : block accepts a bundle this cycle.
- `op`  in  4  : op_t selector. ADDI=0, ADDS=1, SUBS=2, B=3, CBZ=4, BLT=5, LDUR=6, STUR=7, LSL=8, LSR=9, MUL=10.
- `rd`, `rn`, `rm`  in  5 each  : register fields (`rd` is Rt for CBZ, LDUR, and STUR).
- `imm`  in  26  : two's-complement immediate, shift amount, or branch offset.
- `wr_en`  out  1  : instruction-memory write strobe.
- `wr_addr`  out  ADDR_WIDTH  : write word address.
- `wr_data`  out  32  : encoded instruction.
- `count`  out  ADDR_WIDTH+1  : words written this session.
- `done`, `full`, `error`  out  1 each  : status flags, sticky until `start` or reset.

## Operation
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: `in_ready`=1. A handshake is `in_valid & in_ready`.
  - On a handshake with legal fields: the word is written; RUN continues.
  - `finish` → DONE, or the write at IMEM_DEPTH-1 → DONE with `full`=1.
  - An illegal field → ERR. The word is not written and `error`=1.
  - DONE and ERR hold until `start` (→ RUN) or reset. `start` is ignored while in RUN.
- Encodings (bit ranges are [msb:lsb]):
  - R-type (ADDS 10101011000, SUBS 11101011000, LSL 11010011011, LSR 11010011010, MUL 10011011000):
    - Layout: opcode[31:21], Rm[20:16], shamt[15:10], Rn[9:5], Rd[4:0].
    - LSL/LSR: shamt=imm[5:0], Rm=0.
    - MUL: shamt=6'b011111.
    - ADDS/SUBS: shamt=0.
  - ADDI: 1001000100[31:22], imm12[21:10], Rn, Rd.
  - LDUR 11111000010 / STUR 11111000000: opcode[31:21], addr9[20:12], 00[11:10], Rn, Rt.
  - B: 000101[31:26], imm26[25:0].
  - CBZ: 10110100[31:24], imm19[23:5], Rt[4:0].
  - BLT: 01010100[31:24], imm19[23:5], cond=01011[4:0].
- Legality checks (on `imm`):
  - ADDI: 0..4095.
  - LDUR/STUR: -256..255.
  - CBZ/BLT: -2^18..2^18-1.
  - LSL/LSR: 0..63.
  - B: any value.
  - ADDS/SUBS/MUL: `imm` ignored.
  - `op` > 10: illegal.
- Address and count:
  - `wr_addr` increments by 1 after each write.
  - A write never targets an address ≥ IMEM_DEPTH.
  - `count` increments per write.

## Timing
- Reset values: all outputs 0, state IDLE.
- A handshake in cycle N gives `wr_en`=1 in N+1, with that cycle's `wr_addr`/`wr_data`. Throughput is one word per cycle.
- `in_ready` deasserts in the cycle after the write to IMEM_DEPTH-1 is accepted. No further handshake occurs.
- `finish` and a handshake in the same cycle: the bundle is accepted and written in N+1; `done` rises in N+1.
- An illegal bundle in cycle N: `error`=1 in N+1 and `wr_en` stays 0. Earlier pipelined writes still complete.
- `start` in DONE/ERR: in the next cycle `count`=0, flags are 0, and the write pointer is `base_addr`.
- Reset low mid-session: the registered write is dropped (`wr_en`=0 next cycle) and the FSM returns to IDLE.

## Structure
- `legv8_pkg` holds:
  - the `op_t` enum;
  - the 11-bit opcode constants;
  - the BLT cond constant;
  - the MUL shamt constant;
  - field-width and range constants.
- The decoder shares this package.
- Sub-module `legv8_field_encoder`: combinational `op`/fields → {word[31:0], illegal}. The top block holds the FSM, pointer, count and output registers.

## Test plan
- start, base=0, ADDI rd=1 rn=31 imm=5 → `wr_addr`=0, `wr_data`=0x910017E1, `count`=1.
- Back-to-back ADDS(rd=3, rn=1, rm=2) then SUBS(same fields) → consecutive cycles:
  - addr 0: `wr_data`=0xAB020023;
  - addr 1: `wr_data`=0xEB020023.
- B imm=-1 → 0x17FFFFFF; BLT imm=3 → 0x5400006B; MUL rd=4, rn=5, rm=6 → 0x9B067CA4.
- LDUR rd=2, rn=0, imm=256 → `error`=1, no `wr_en`. Further `in_valid` is ignored until `start`.
- base=IMEM_DEPTH-2, three bundles → two writes, `full`=1 and `done`=1, `count`=2, third not accepted.
- Reset asserted during a write cycle → all outputs 0 next cycle; after `start`, `count` restarts at 0.
